imem_boot_loader: RTL and testbench

- Boot-time controller that fills the instruction memory before the single-cycle RISC-V core runs.
- Accepts a byte stream over a valid/ready handshake and packs each group of 4 bytes into a little-endian 32-bit word.
- Issues one-cycle word writes at word-aligned byte addresses.
- Holds the core in reset until the image has loaded, then releases it.

---
 rtl/imem_boot_loader.sv | 166 ++++++++++++++++
 tb/tb_imem_boot_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: packs a little-endian byte stream into 32-bit instruction-memory writes
// and holds the core in reset until the image is loaded. Optional checksum: IMEM_BOOT_CHECKSUM_EN.
module imem_boot_loader #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_words,
    input  logic [7:0]       in_byte,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             mem_we,
    output logic [31:0]      mem_waddr,
    output logic [31:0]      mem_wdata,
    output logic             cpu_rst_n,
    output logic             busy,
    output logic             done,
    output logic             error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
`ifdef IMEM_BOOT_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [23:0]      word_q, word_d;
    logic [CNT_W-1:0] word_idx_q, word_idx_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [31:0]      waddr_q, waddr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             error_q, error_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
`endif

    logic [CNT_W-1:0] word_inc;
    assign word_inc = word_idx_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            word_q     <= '0;
            word_idx_q <= '0;
            num_q      <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            error_q    <= 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            word_idx_q <= word_idx_d;
            num_q      <= num_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            error_q    <= error_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        word_idx_d = word_idx_q;
        num_d      = num_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        error_d    = error_q;
`ifdef IMEM_BOOT_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (num_words > CNT_W'(DEPTH)) begin
                        error_d = 1'b1;
                    end else begin
                        error_d    = 1'b0;
                        byte_cnt_d = '0;
                        word_idx_d = '0;
                        num_d      = num_words;
`ifdef IMEM_BOOT_CHECKSUM_EN
                        csum_d     = '0;
`endif
                        state_d    = (num_words == '0) ? S_DONE : S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_BOOT_CHECKSUM_EN
                    csum_d     = csum_q ^ in_byte;
`endif
                    case (byte_cnt_q)
                        2'd0: word_d[7:0]   = in_byte;
                        2'd1: word_d[15:8]  = in_byte;
                        2'd2: word_d[23:16] = in_byte;
                        default: begin
                            // Last byte bypasses the assembly register straight into the write data.
                            waddr_d = 32'({word_idx_q, 2'b00});
                            wdata_d = {in_byte, word_q};
                            state_d = S_WRITE;
                        end
                    endcase
                end
            end
            S_WRITE: begin
                word_idx_d = word_inc;
                if (word_inc == num_q) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_LOAD;
                end
            end
`ifdef IMEM_BOOT_CHECKSUM_EN
            S_CHECK: begin
                if (in_valid) begin
                    if (in_byte == csum_q) begin
                        state_d = S_DONE;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

`ifdef IMEM_BOOT_CHECKSUM_EN
    assign in_ready = (state_q == S_LOAD) || (state_q == S_CHECK);
    assign busy     = (state_q == S_LOAD) || (state_q == S_WRITE) || (state_q == S_CHECK);
`else
    assign in_ready = (state_q == S_LOAD);
    assign busy     = (state_q == S_LOAD) || (state_q == S_WRITE);
`endif
    assign mem_we    = (state_q == S_WRITE) && (word_idx_q < CNT_W'(DEPTH));
    assign mem_waddr = waddr_q;
    assign mem_wdata = wdata_q;
    assign cpu_rst_n = (state_q == S_DONE);
    assign done      = (state_q == S_DONE);
    assign error     = error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected writes are queued as bytes are driven
// and checked against every mem_we pulse.
module tb_imem_boot_loader;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_words = '0;
    logic [7:0]       in_byte = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             mem_we;
    logic [31:0]      mem_waddr;
    logic [31:0]      mem_wdata;
    logic             cpu_rst_n;
    logic             busy;
    logic             done;
    logic             error;

    imem_boot_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_words (num_words),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned cyc = 0;
    int unsigned t0 = 0;
    logic [63:0] sb[$];
    logic [7:0]  tx_q[$];
    logic [63:0] mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we) begin
            check_eq("waddr_range", 32'(mem_waddr < 32'(DEPTH * 4)), 32'd1);
            if (sb.size() == 0) begin
                check_eq("unexpected_we", 32'(mem_we), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("waddr", mem_waddr, mon_e[63:32]);
                check_eq("wdata", mem_wdata, mon_e[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int unsigned nw);
        start = 1'b1;
        num_words = CNT_W'(nw);
        tick();
        start = 1'b0;
    endtask

    task automatic expect_write(input logic [31:0] addr, input logic [31:0] data);
        sb.push_back({addr, data});
    endtask

    task automatic send_bytes(input int unsigned gap);
        int unsigned budget;
        while (tx_q.size() != 0) begin
            budget = 0;
            in_byte = tx_q.pop_front();
            in_valid = 1'b1;
            @(negedge clk);
            while (!in_ready && budget < 50) begin
                budget++;
                @(negedge clk);
            end
            if (!in_ready) begin
                check_eq("in_ready_timeout", 32'(in_ready), 32'd1);
                in_valid = 1'b0;
                tx_q.delete();
                return;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic wait_done();
        int unsigned budget = 0;
        @(negedge clk);
        while (!done && budget < 100) begin
            budget++;
            @(negedge clk);
        end
        check_eq("done", 32'(done), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        check_eq({tag, "_ctl"}, {26'd0, in_ready, mem_we, cpu_rst_n, busy, done, error}, 32'd0);
        check_eq({tag, "_waddr"}, mem_waddr, 32'd0);
        check_eq({tag, "_wdata"}, mem_wdata, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst");
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        logic [31:0] w;
        repeat (2) tick();
        do_reset();

        // Two-word image, valid every cycle, with latency from first byte to done
        do_start(2);
        check_eq("busy_load", 32'(busy), 32'd1);
        expect_write(32'h0, 32'h0000_0513);
        expect_write(32'h4, 32'h0010_0093);
        tx_q = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        t0 = cyc;
        send_bytes(0);
        wait_done();
        check_eq("done_latency", cyc - t0, 32'd10);
        check_eq("cpu_rst_rel", 32'(cpu_rst_n), 32'd1);

        // Single word with in_valid toggling
        do_start(1);
        check_eq("cpu_rst_reentry1", 32'(cpu_rst_n), 32'd0);
        expect_write(32'h0, 32'hDEAD_BEEF);
        tx_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_bytes(1);
        wait_done();
        repeat (5) tick();

        // Out-of-range start from IDLE, then recovery
        do_reset();
        do_start(9);
        check_eq("oor_status", {28'd0, error, busy, done, cpu_rst_n}, 32'h8);
        repeat (3) tick();
        check_eq("oor_held", {28'd0, error, busy, done, cpu_rst_n}, 32'h8);
        do_start(1);
        check_eq("err_clear", {30'd0, error, busy}, 32'h1);
        expect_write(32'h0, 32'h4433_2211);
        tx_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_bytes(0);
        wait_done();

        // Out-of-range start from DONE keeps DONE
        tick();
        do_start(15);
        check_eq("oor_done", {28'd0, error, busy, done, cpu_rst_n}, 32'hB);

        // Reset after two bytes of a word
        do_start(1);
        tx_q = '{8'h55, 8'h66};
        send_bytes(0);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("midrst");
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        check_eq("post_rst_idle", {29'd0, busy, done, cpu_rst_n}, 32'd0);
        do_start(1);
        expect_write(32'h0, 32'hDDCC_BBAA);
        tx_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_bytes(0);
        wait_done();

        // Zero-word start goes straight to done
        tick();
        do_start(0);
        check_eq("zero_words", {29'd0, busy, done, cpu_rst_n}, 32'h3);

        // Full-depth reload from DONE with an ignored start mid-load
        do_start(8);
        check_eq("cpu_rst_reentry8", 32'(cpu_rst_n), 32'd0);
        for (int unsigned i = 0; i < 8; i++) begin
            w = {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)};
            expect_write(32'(4 * i), w);
        end
        for (int unsigned i = 0; i < 10; i++) tx_q.push_back(8'(i));
        send_bytes(0);
        start = 1'b1;
        num_words = CNT_W'(1);
        tick();
        start = 1'b0;
        check_eq("start_ignored", 32'(busy), 32'd1);
        for (int unsigned i = 10; i < 32; i++) tx_q.push_back(8'(i));
        send_bytes(0);
        wait_done();
        check_eq("full_cpu_rel", 32'(cpu_rst_n), 32'd1);

`ifdef IMEM_BOOT_CHECKSUM_EN
        tick();
        do_start(1);
        expect_write(32'h0, 32'h0804_0201);
        tx_q = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};
        send_bytes(0);
        wait_done();
        check_eq("csum_ok_err", 32'(error), 32'd0);
        tick();
        do_start(1);
        expect_write(32'h0, 32'h0804_0201);
        tx_q = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h0E};
        send_bytes(0);
        check_eq("csum_bad", {28'd0, error, busy, done, cpu_rst_n}, 32'h8);
        repeat (3) tick();
        check_eq("csum_bad_held", {28'd0, error, busy, done, cpu_rst_n}, 32'h8);
`endif

        repeat (5) tick();
        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
